// File: rtl/envelope_gen_pkg.sv
// Shared types and saturating helpers for the ADSR envelope stage.
package envelope_gen_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

    // a + b clamped to ceil_v.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] ceil_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil_v}) ? ceil_v : sum[31:0];
    endfunction

    // a - b clamped to floor_v; assumes a >= floor_v on entry.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] floor_v);
        if ((a < b) || ((a - b) < floor_v)) begin
            return floor_v;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/envelope_gen_level_fsm.sv
// ADSR level state machine; advances one step per accepted sample.
// ENVELOPE_GEN_EXP_RELEASE_EN selects an exponential release tail.
module env_level_fsm
    import envelope_gen_pkg::*;
#(
    parameter int unsigned env_width_p     = 8,
    parameter int unsigned attack_step_p   = 32,
    parameter int unsigned decay_step_p    = 8,
    parameter int unsigned sustain_level_p = 160,
    parameter int unsigned release_step_p  = 4,
    parameter int unsigned release_shift_p = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   step_i,
    input  logic                   gate_i,
    output logic [env_width_p-1:0] env_o,
    output env_state_e             state_o
);

    localparam logic [31:0] MAX_LEVEL = (32'd1 << env_width_p) - 32'd1;
    localparam logic [31:0] SUS_LEVEL = 32'(sustain_level_p);

    env_state_e             state_q, state_d;
    logic [env_width_p-1:0] env_q, env_d;
    logic [31:0]            level, rel_dec, att_level, dec_level, rel_level;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Gate changes take effect on the same beat, using the new state's step.
    always_comb begin
        level = 32'(env_q);
`ifdef ENVELOPE_GEN_EXP_RELEASE_EN
        rel_dec = level >> release_shift_p;
        if (rel_dec == 32'd0) begin
            rel_dec = 32'd1;
        end
`else
        rel_dec = 32'(release_step_p);
`endif
        att_level = sat_add(level, 32'(attack_step_p), MAX_LEVEL);
        dec_level = sat_sub(level, 32'(decay_step_p), SUS_LEVEL);
        rel_level = sat_sub(level, rel_dec, 32'd0);
        state_d   = state_q;
        env_d     = env_q;
        if (step_i) begin
            if (!gate_i) begin
                if (state_q != IDLE) begin
                    env_d   = env_width_p'(rel_level);
                    state_d = (rel_level == 32'd0) ? IDLE : RELEASE;
                end
            end else begin
                case (state_q)
                    IDLE, ATTACK, RELEASE: begin
                        env_d   = env_width_p'(att_level);
                        state_d = (att_level == MAX_LEVEL) ? DECAY : ATTACK;
                    end
                    DECAY: begin
                        env_d   = env_width_p'(dec_level);
                        state_d = (dec_level == SUS_LEVEL) ? SUSTAIN : DECAY;
                    end
                    SUSTAIN: begin
                        env_d   = env_width_p'(SUS_LEVEL);
                        state_d = SUSTAIN;
                    end
                    default: begin
                        env_d   = '0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        env_o   = env_q;
        state_o = state_q;
    end

endmodule

// File: rtl/envelope_gen.sv
// ADSR amplitude envelope: scales a signed sample stream by an 8-bit level.
// Build with ENVELOPE_GEN_EXP_RELEASE_EN for an exponential release tail.
module envelope_gen
    import envelope_gen_pkg::*;
#(
    parameter int unsigned width_p         = 12,
    parameter int unsigned env_width_p     = 8,
    parameter int unsigned attack_step_p   = 32,
    parameter int unsigned decay_step_p    = 8,
    parameter int unsigned sustain_level_p = 160,
    parameter int unsigned release_step_p  = 4,
    parameter int unsigned release_shift_p = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      gate_i,
    input  logic signed [width_p-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic signed [width_p-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [env_width_p-1:0]    env_o,
    output logic                      busy_o
);

    localparam int unsigned PROD_W = width_p + env_width_p + 1;

    logic                     accept_in;
    env_state_e               state;
    logic signed [PROD_W-1:0] product;
    logic                     unused_product_bits;

    // valid/ready: a beat moves when valid & ready are both high at a rising
    // edge; a presented output holds data and valid until it is taken, and the
    // single output register can refill in the same cycle it drains.
    assign ready_o   = ~valid_o | ready_i;
    assign accept_in = valid_i & ready_o;

    env_level_fsm #(
        .env_width_p    (env_width_p),
        .attack_step_p  (attack_step_p),
        .decay_step_p   (decay_step_p),
        .sustain_level_p(sustain_level_p),
        .release_step_p (release_step_p),
        .release_shift_p(release_shift_p)
    ) u_level (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .step_i  (accept_in),
        .gate_i  (gate_i),
        .env_o   (env_o),
        .state_o (state)
    );

    // Level is zero-extended so the product stays signed; taking the upper
    // slice is an arithmetic shift that floors toward -inf.
    assign product = PROD_W'(data_i) * PROD_W'($signed({1'b0, env_o}));
    assign unused_product_bits = ^{product[PROD_W-1], product[env_width_p-1:0]};

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (accept_in) begin
            valid_o <= 1'b1;
            data_o  <= product[env_width_p +: width_p];
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Scoreboard bench for envelope_gen against an arithmetic ADSR reference model.
module tb_envelope_gen;

    localparam int W    = 12;
    localparam int EW   = 8;
    localparam int ATT  = 32;
    localparam int DEC  = 8;
    localparam int SUS  = 160;
    localparam int REL  = 4;
    localparam int RSH  = 3;
    localparam int MAXL = 255;

    localparam int P_IDLE = 0;
    localparam int P_ATT  = 1;
    localparam int P_DEC  = 2;
    localparam int P_SUS  = 3;
    localparam int P_REL  = 4;

    logic                clk_i = 1'b0;
    logic                reset_ni = 1'b0;
    logic                gate_i = 1'b0;
    logic                valid_i = 1'b0;
    logic                ready_i = 1'b0;
    logic signed [W-1:0] data_i = '0;
    logic                ready_o, valid_o, busy_o;
    logic signed [W-1:0] data_o;
    logic [EW-1:0]       env_o;

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];
    int         m_env = 0;
    int         m_phase = P_IDLE;
    bit         rand_ready = 1'b0;

    envelope_gen dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .gate_i  (gate_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .env_o   (env_o),
        .busy_o  (busy_o)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int floor_scale(input int d, input int e);
        int p, q;
        p = d * e;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int release_dec(input int e);
`ifdef ENVELOPE_GEN_EXP_RELEASE_EN
        return ((e >> RSH) > 1) ? (e >> RSH) : 1;
`else
        return REL + 0 * e;
`endif
    endfunction

    function automatic int release_beats(input int start);
        int e, n;
        e = start;
        n = 0;
        while (e > 0) begin
            e = (e > release_dec(e)) ? e - release_dec(e) : 0;
            n++;
        end
        return n;
    endfunction

    task automatic model_beat(input logic g);
        if (!g) begin
            if (m_phase != P_IDLE) begin
                m_env   = (m_env > release_dec(m_env)) ? m_env - release_dec(m_env) : 0;
                m_phase = (m_env == 0) ? P_IDLE : P_REL;
            end
        end else if (m_phase == P_DEC) begin
            m_env   = (m_env - DEC > SUS) ? m_env - DEC : SUS;
            m_phase = (m_env == SUS) ? P_SUS : P_DEC;
        end else if (m_phase == P_SUS) begin
            m_env = SUS;
        end else begin
            m_env   = (m_env + ATT < MAXL) ? m_env + ATT : MAXL;
            m_phase = (m_env == MAXL) ? P_DEC : P_ATT;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_i);
        #1 ready_i = v;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input int d, input logic g);
        int waited;
        waited  = 0;
        data_i  = W'(d);
        gate_i  = g;
        valid_i = 1'b1;
        while (!ready_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready_o=0 for %0d cycles required ready_o=1", waited);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        exp_q.push_back(W'(floor_scale(d, m_env)));
        model_beat(g);
        @(negedge clk_i);
        check("env_after_beat", env_o, m_env);
        check("busy_after_beat", busy_o, (m_phase != P_IDLE) ? 1 : 0);
    endtask

    // ---------------- random backpressure ----------------
    initial forever begin
        @(posedge clk_i);
        #1;
        if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic         stall;
        logic [W-1:0] held;
        logic [W-1:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", valid_o, 1);
                    check("hold_data", $signed(data_o), $signed(held));
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data_o=%0d required no output", $signed(data_o));
                    end else begin
                        e = exp_q.pop_front();
                        check("data_o", $signed(data_o), $signed(e));
                    end
                end
                stall = valid_o && !ready_i;
                held  = data_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  cnt, run;
        logic g;

        // reset held with valid_i asserted
        reset_ni = 1'b0;
        valid_i  = 1'b1;
        data_i   = W'(1000);
        gate_i   = 1'b1;
        ready_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_valid_o", valid_o, 0);
        check("reset_data_o", data_o, 0);
        check("reset_env_o", env_o, 0);
        check("reset_busy_o", busy_o, 0);
        check("reset_ready_o", ready_o, 1);
        valid_i  = 1'b0;
        gate_i   = 1'b0;
        reset_ni = 1'b1;
        set_ready(1'b1);

        // attack to peak then decay to sustain; first beat uses env=0
        for (int i = 1; i <= 20; i++) begin
            send((i == 1) ? -2048 : 1000, 1'b1);
            if (i == 8) check("env_peak", env_o, MAXL);
        end
        check("env_sustain", env_o, SUS);
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 4095)) - 2048, 1'b1);
        check("env_sustain_hold", env_o, SUS);

        // backpressure: one output parked, next beat stalled for 5 cycles
        idle(2);
        set_ready(1'b0);
        send(700, 1'b1);
        data_i  = W'(-500);
        gate_i  = 1'b1;
        valid_i = 1'b1;
        repeat (5) begin
            check("bp_ready_o", ready_o, 0);
            check("bp_env_o", env_o, SUS);
            @(negedge clk_i);
        end
        set_ready(1'b1);
        send(-500, 1'b1);

        // release to idle
        cnt = 0;
        while (busy_o && cnt < 400) begin
            send(int'($urandom_range(0, 4095)) - 2048, 1'b0);
            cnt++;
        end
        check("release_beats", cnt, release_beats(SUS));
        check("release_env_o", env_o, 0);
        check("release_busy_o", busy_o, 0);

        // retrigger during attack
        for (int i = 0; i < 3; i++) send(1000, 1'b1);
        check("retrig_env_96", env_o, 96);
        send(1000, 1'b0);
        check("retrig_release", env_o, 96 - release_dec(96));
        send(1000, 1'b1);
        check("retrig_attack", env_o, 96 - release_dec(96) + ATT);
        for (int i = 0; i < 5; i++) send(1000, 1'b1);
        check("retrig_peak", env_o, MAXL);
        send(-1000, 1'b1);

        // reset mid-note
        idle(2);
        check("drain_before_reset", exp_q.size(), 0);
        reset_ni = 1'b0;
        @(negedge clk_i);
        check("midnote_env_o", env_o, 0);
        check("midnote_busy_o", busy_o, 0);
        check("midnote_valid_o", valid_o, 0);
        reset_ni = 1'b1;
        m_env    = 0;
        m_phase  = P_IDLE;
        exp_q.delete();

        // randomized traffic with random backpressure and idle gaps
        rand_ready = 1'b1;
        g = 1'b0;
        run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                g   = ~g;
                run = $urandom_range(1, 60);
            end
            run--;
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            case ($urandom_range(0, 5))
                0:       send(-2048, g);
                1:       send(2047, g);
                default: send(int'($urandom_range(0, 4095)) - 2048, g);
            endcase
        end
        idle(1);
        rand_ready = 1'b0;
        set_ready(1'b1);
        idle(4);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
